// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply dispatcher and the multiplier it drives.
package matmul_pkg;

  localparam int SEQ_BITS = 14;
  localparam int DIM = SEQ_BITS + 1;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_A    = 3'd1,
    LOAD_B    = 3'd2,
    KICK      = 3'd3,
    WAIT_BUSY = 3'd4,
    WAIT_DONE = 3'd5,
    STORE_C   = 3'd6,
    FINISH    = 3'd7
  } state_t;

endpackage

// File: rtl/matmul_addr_gen.sv
// Row/col element walker: col-major stepping within a row, wrapping to (0,0) after the last
// element, and the byte address base + 4*(row*DIM + col) modulo 2^ADDR_W.
module matmul_addr_gen #(
  parameter int DIM = 15,
  parameter int ADDR_W = 32,
  parameter int IDX_W = (DIM > 1) ? $clog2(DIM) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              step,
  input  logic [ADDR_W-1:0] base,
  output logic [ADDR_W-1:0] addr,
  output logic [IDX_W-1:0]  row,
  output logic [IDX_W-1:0]  col,
  output logic              last
);

  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(DIM - 1);

  logic [ADDR_W-1:0] lin;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (step) begin
      if (col == MAX_IDX) begin
        col <= '0;
        row <= (row == MAX_IDX) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_comb begin
    lin  = ADDR_W'(row) * ADDR_W'(DIM) + ADDR_W'(col);
    addr = base + (lin << 2);
    last = (row == MAX_IDX) && (col == MAX_IDX);
  end

endmodule

// File: rtl/matmul_dispatcher.sv
// Loads A and B from memory into the multiplier, kicks it, waits for the done edge pair,
// then streams C back to memory and pulses cmd_done.
module matmul_dispatcher
  import matmul_pkg::*;
#(
  parameter int DIM = 15,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_start,
  input  logic [ADDR_W-1:0] cmd_base_a,
  input  logic [ADDR_W-1:0] cmd_base_b,
  input  logic [ADDR_W-1:0] cmd_base_c,
  output logic              busy,
  output logic              cmd_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              mm_enable,
  output logic [31:0]       mm_matrixA [DIM][DIM],
  output logic [31:0]       mm_matrixB [DIM][DIM],
  input  logic [31:0]       mm_matrixC [DIM][DIM],
  input  logic              mm_done,
  output logic [2:0]        fsm_state
);

  localparam int IDX_W = (DIM > 1) ? $clog2(DIM) : 1;

  state_t            state, next_state;
  logic [ADDR_W-1:0] base_a, base_b, base_c, cur_base, elem_addr;
  logic [IDX_W-1:0]  row, col;
  logic              last, accept, mem_acc;
  word_t             c_word;

  // Memory handshake: mem_req stays high with addr/we/wdata held until a cycle with mem_ack=1;
  // that edge completes the transfer and the next element is presented on the following cycle.
  // An ack while mem_req=0 has no effect because mem_acc is gated by mem_req.
  assign accept  = (state == IDLE) && cmd_start;
  assign mem_acc = mem_req && mem_ack;
  assign fsm_state = state;

  always_comb begin
    cur_base = base_c;
    if (state == LOAD_A) cur_base = base_a;
    else if (state == LOAD_B) cur_base = base_b;
  end

  matmul_addr_gen #(
    .DIM(DIM),
    .ADDR_W(ADDR_W),
    .IDX_W(IDX_W)
  ) u_addr_gen (
    .clk(clk),
    .reset(reset),
    .clr(accept),
    .step(mem_acc),
    .base(cur_base),
    .addr(elem_addr),
    .row(row),
    .col(col),
    .last(last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:      if (cmd_start) next_state = LOAD_A;
      LOAD_A:    if (mem_acc && last) next_state = LOAD_B;
      LOAD_B:    if (mem_acc && last) next_state = KICK;
      KICK:      next_state = WAIT_BUSY;
      WAIT_BUSY: if (!mm_done) next_state = WAIT_DONE;
      WAIT_DONE: if (mm_done) next_state = STORE_C;
      STORE_C:   if (mem_acc && last) next_state = FINISH;
      FINISH:    next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  assign c_word = mm_matrixC[row][col];

  always_comb begin
    busy      = (state != IDLE);
    cmd_done  = (state == FINISH);
    mm_enable = (state == KICK);
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state)
      LOAD_A, LOAD_B: begin
        mem_req  = 1'b1;
        mem_addr = elem_addr;
      end
      STORE_C: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = elem_addr;
        mem_wdata = c_word;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_a <= '0;
      base_b <= '0;
      base_c <= '0;
    end else if (accept) begin
      base_a <= cmd_base_a;
      base_b <= cmd_base_b;
      base_c <= cmd_base_c;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < DIM; r++) begin
        for (int c = 0; c < DIM; c++) begin
          mm_matrixA[r][c] <= '0;
          mm_matrixB[r][c] <= '0;
        end
      end
    end else if (mem_acc) begin
      if (state == LOAD_A) mm_matrixA[row][col] <= mem_rdata;
      if (state == LOAD_B) mm_matrixB[row][col] <= mem_rdata;
    end
  end

endmodule

// File: doc/matmul_dispatcher.md
MATMUL_DISPATCHER -- requirements
Module: matmul_dispatcher

Interface
REQ-001 Parameter DIM, default 15, SHALL set the matrix edge length (row/column indices 0..DIM-1).
REQ-002 Parameter ADDR_W, default 32, SHALL set the memory address width.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, SHALL be the asynchronous, active-high reset.
REQ-005 Port cmd_start, input, 1, SHALL be the job request; it is sampled only in IDLE.
REQ-006 Ports cmd_base_a/cmd_base_b/cmd_base_c, input, ADDR_W, SHALL be the byte base addresses of A, B and C; they are captured when cmd_start is accepted.
REQ-007 Ports busy, output, 1 (high when state is not IDLE), and cmd_done, output, 1 (one-cycle completion pulse), SHALL report job status.
REQ-008 Memory port, all outputs except mem_rdata/mem_ack, SHALL comprise mem_req 1, mem_we 1, mem_addr ADDR_W, mem_wdata 32, mem_rdata 32 (input) and mem_ack 1 (input).
REQ-009 Multiplier port SHALL comprise mm_enable 1 (output), mm_matrixA/mm_matrixB [DIM][DIM]x32 (outputs), mm_matrixC [DIM][DIM]x32 (input) and mm_done 1 (input).

Function
REQ-010 The FSM SHALL have states IDLE, LOAD_A, LOAD_B, KICK, WAIT_BUSY, WAIT_DONE, STORE_C and FINISH.
REQ-011 In IDLE with cmd_start=1, the block SHALL capture the bases, clear row/col to 0 and go to LOAD_A on the next edge.
REQ-012 Element (r,c) SHALL use address base + 4*(r*DIM + c); the index increments col first and wraps col DIM-1->0 with row+1.
REQ-013 Memory handshake: mem_req SHALL be held with mem_addr/mem_we/mem_wdata stable until the cycle mem_ack=1; only one request is outstanding, and a new request may be issued the cycle after the ack.
REQ-014 In LOAD_A/LOAD_B, mem_we=0, and on ack mem_rdata SHALL be written into mm_matrixA[r][c]/mm_matrixB[r][c].
REQ-015 An ack at (DIM-1,DIM-1) SHALL move LOAD_A->LOAD_B or LOAD_B->KICK and reset the index to (0,0).
REQ-016 KICK SHALL assert mm_enable for exactly one cycle, then go to WAIT_BUSY.
REQ-017 WAIT_BUSY SHALL wait for mm_done=0 (the multiplier idles with done=1), then go to WAIT_DONE.
REQ-018 WAIT_DONE SHALL wait for mm_done=1, then go to STORE_C.
REQ-019 STORE_C SHALL write mm_matrixC[r][c] with mem_we=1 to the C address; the ack at (DIM-1,DIM-1) goes to FINISH.
REQ-020 FINISH SHALL pulse cmd_done for one cycle and return to IDLE.
REQ-021 cmd_start asserted while busy=1 SHALL be ignored, with no queuing.
REQ-022 Address arithmetic SHALL wrap modulo 2^ADDR_W with no error flag.
REQ-023 A mem_ack arriving while mem_req=0 SHALL be ignored.
REQ-024 A single job SHALL perform exactly 3*DIM*DIM memory transactions.

Reset
REQ-025 On reset=1, asynchronously: state=IDLE, busy=0, cmd_done=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mm_enable=0, all mm_matrixA/B entries=0, row/col=0, bases=0.
REQ-026 Reset asserted mid-job SHALL abandon the job immediately: no cmd_done is produced and mem_req drops asynchronously.

Structure
REQ-027 Package matmul_pkg SHALL hold SEQ_BITS=14, DIM=SEQ_BITS+1, the 32-bit word typedef and the FSM state enum, shared with the multiplier.
REQ-028 Row/col counting, wrap and address generation SHALL live in sub-module matmul_addr_gen (inputs clr, step, base; outputs addr, last).

Verification
REQ-029 Bench SHALL cover: A=identity, B[r][c]=r*15+c, bases 0x0000/0x1000/0x2000, zero-wait ack -> C region equals B, 675 transactions, one cmd_done.
REQ-030 Bench SHALL cover: random 0-3 cycle ack delay -> mem_addr/mem_wdata stable while mem_req=1 and un-acked, with the same result as zero-wait.
REQ-031 Bench SHALL cover: cmd_start pulsed during LOAD_B -> ignored, exactly one cmd_done, and bases unchanged.
REQ-032 Bench SHALL cover: reset asserted during STORE_C element (3,7) -> mem_req=0 in the same cycle, busy=0, and a new job then completes correctly.
REQ-033 Bench SHALL cover: the model holds mm_done=1 for 5 cycles after mm_enable -> dispatcher stays in WAIT_BUSY with no STORE_C writes until done falls and rises again.
REQ-034 Bench SHALL cover: cmd_base_c=0xFFFFFFF0 -> the element (0,4) address wraps to 0x00000000.
